digit_position_counter: RTL and testbench
=========================================

DIGIT_POSITION_COUNTER -- requirements
Module: digit_position_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MIN_VAL, default 1: lowest in-range count value.
REQ-003 Parameter MAX_VAL, default 5: highest in-range count value.
REQ-004 Parameter DEB_CYCLES, default 16: number of stable samples required by the debounce filter.
REQ-005 Port Clk, input, 1 bit: single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port Reset, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port StartCount, input, 1 bit: raw toggle-button level; each press SHALL produce one step.
REQ-008 Port Down, input, 1 bit: step direction (0 = up, 1 = down).
REQ-009 Port Mode, input, 1 bit: boundary mode (0 = wrap, 1 = saturate).
REQ-010 Port Clear, input, 1 bit: synchronous clear to 0.
REQ-011 Port Load, input, 1 bit: synchronous load of LoadValue.
REQ-012 Port LoadValue, input, WIDTH bits: value to load.
REQ-013 Port CounterValue, output, WIDTH bits: registered count.
REQ-014 Port Wrap, output, 1 bit: one-cycle pulse on each wrap-around.
REQ-015 Port AtMax / AtMin, output, 1 bit each: registered flags, CounterValue==MAX_VAL / CounterValue==MIN_VAL.

Function
REQ-016 Step SHALL be generated from the rising edge of the filtered press level (press_q set, press_qq clear); holding StartCount high SHALL yield exactly one step.
REQ-017 Without debounce, StartCount high first sampled at edge N SHALL update CounterValue at edge N+1.
REQ-018 Priority SHALL be Reset > Clear > Load > step; a step coinciding with Clear or Load SHALL be dropped.
REQ-019 Clear SHALL set CounterValue to 0 and deassert Wrap.
REQ-020 Load SHALL set CounterValue to LoadValue clamped to [MIN_VAL, MAX_VAL].
REQ-021 Up step with MIN_VAL <= value < MAX_VAL: value+1; down step with MIN_VAL < value <= MAX_VAL: value-1.
REQ-022 Up step at MAX_VAL: wrap mode -> MIN_VAL and Wrap=1 for one cycle; saturate mode -> hold, Wrap=0.
REQ-023 Down step at MIN_VAL: wrap mode -> MAX_VAL and Wrap=1 for one cycle; saturate mode -> hold, Wrap=0.
REQ-024 Step while the value is out of range (including 0 after reset/Clear): up -> MIN_VAL, down -> MAX_VAL; Wrap=0.
REQ-025 Down and Mode SHALL be sampled in the cycle the step is applied; changing them mid-press SHALL have no other effect.
REQ-026 AtMax/AtMin SHALL reflect the new CounterValue in the same cycle it is registered.
REQ-027 Parameters SHALL satisfy 0 <= MIN_VAL <= MAX_VAL <= 2**WIDTH-1 and DEB_CYCLES >= 2; violation SHALL be an elaboration error.

Reset
REQ-028 Reset low at a Clk edge SHALL set CounterValue=0, Wrap=0, AtMax=0, AtMin=(MIN_VAL==0), and clear the edge-detect and debounce state.
REQ-029 Reset asserted mid-press SHALL discard the press; the level still held after release of Reset SHALL NOT produce a step until StartCount has been low once.

Configuration
REQ-030 Macro DIGITCOUNT_DEBOUNCE_EN defined: StartCount SHALL pass through a two-flop synchronizer and a filter that changes its output only after DEB_CYCLES consecutive equal samples; step latency becomes DEB_CYCLES+3 edges.
REQ-031 Macro undefined: the filter SHALL be absent, StartCount SHALL feed the edge detector directly, and the DEB_CYCLES parameter SHALL be ignored.

Structure
REQ-032 Package digit_count_pkg SHALL hold the Mode encodings (MODE_WRAP, MODE_SAT), the direction encodings, and the default WIDTH/MIN_VAL/MAX_VAL constants.
REQ-033 The debounce filter SHALL be a sub-module press_debounce, instantiated only under DIGITCOUNT_DEBOUNCE_EN.

Verification (defaults, macro undefined unless stated)
REQ-034 Reset, then 6 up presses in wrap mode -> 1,2,3,4,5,1; Wrap pulses once, on the 5->1 step.
REQ-035 Saturate mode, Load 5, then 2 up presses -> holds 5, AtMax=1, Wrap never asserted.
REQ-036 Down, wrap mode, from 0: presses -> 5,4,3,2,1,5; Wrap pulses on the 1->5 step.
REQ-037 Load with LoadValue=9 -> 5; Load with LoadValue=0 -> 1; Clear coinciding with a press edge -> 0 with no step.
REQ-038 StartCount held high for 20 cycles -> exactly one increment; Reset pulsed mid-hold -> value 0 and no step until release and re-press.
REQ-039 DIGITCOUNT_DEBOUNCE_EN defined: a 5-cycle glitch produces no step; a 30-cycle press produces one step at edge DEB_CYCLES+3.

Source files
------------

// File: rtl/digit_position_counter_pkg.sv
// ---------------------------------------------------------------------------
// digit_count_pkg
// Shared encodings and default constants for the digit position counter.
//   mode_e : boundary behaviour selected by the Mode input
//   dir_e  : step direction selected by the Down input
//   DEFAULT_* : default parameter values used by the counter and interface
// ---------------------------------------------------------------------------
package digit_count_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int DEFAULT_WIDTH      = 4;
    localparam int DEFAULT_MIN_VAL    = 1;
    localparam int DEFAULT_MAX_VAL    = 5;
    localparam int DEFAULT_DEB_CYCLES = 16;

endpackage

// File: rtl/digit_position_counter_if.sv
// ---------------------------------------------------------------------------
// digit_position_counter_if
// Control/status bundle of the digit position counter.
//   master : drives StartCount, Down, Mode, Clear, Load, LoadValue;
//            observes CounterValue, Wrap, AtMax, AtMin
//   slave  : the counter itself (mirror directions)
// Parameter WIDTH must match the counter's WIDTH.
// ---------------------------------------------------------------------------
interface digit_position_counter_if
    import digit_count_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             StartCount;
    logic             Down;
    logic             Mode;
    logic             Clear;
    logic             Load;
    logic [WIDTH-1:0] LoadValue;
    logic [WIDTH-1:0] CounterValue;
    logic             Wrap;
    logic             AtMax;
    logic             AtMin;

    modport master (
        output StartCount, Down, Mode, Clear, Load, LoadValue,
        input  CounterValue, Wrap, AtMax, AtMin
    );

    modport slave (
        input  StartCount, Down, Mode, Clear, Load, LoadValue,
        output CounterValue, Wrap, AtMax, AtMin
    );
endinterface

// File: rtl/digit_position_counter_press_debounce.sv
// ---------------------------------------------------------------------------
// press_debounce
// Two-flop synchronizer followed by a stability filter for the raw button
// level. The filtered output only changes after DEB_CYCLES consecutive
// synchronized samples that disagree with it.
// Only compiled when DIGITCOUNT_DEBOUNCE_EN is defined.
// Ports:
//   Clk           : clock, rising edge
//   Reset         : synchronous, active-low
//   RawLevel      : asynchronous button level
//   SyncLevel     : synchronized (unfiltered) level
//   FilteredLevel : debounced level, registered
// ---------------------------------------------------------------------------
`ifdef DIGITCOUNT_DEBOUNCE_EN
module press_debounce
    import digit_count_pkg::*;
#(
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
    input  logic Clk,
    input  logic Reset,
    input  logic RawLevel,
    output logic SyncLevel,
    output logic FilteredLevel
);
    localparam int              CW     = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0]   RELOAD = CW'(DEB_CYCLES - 1);

    logic          syncA;
    logic          syncB;
    logic [CW-1:0] stableCnt;

    // The synchronizer resets to "pressed" so a button held through reset
    // never looks like it was released; the counter's arming logic relies
    // on seeing a genuine low after reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            syncA         <= 1'b1;
            syncB         <= 1'b1;
            FilteredLevel <= 1'b0;
            stableCnt     <= RELOAD;
        end else begin
            syncA <= RawLevel;
            syncB <= syncA;
            if (syncB == FilteredLevel) begin
                stableCnt <= RELOAD;
            end else if (stableCnt == '0) begin
                FilteredLevel <= syncB;
                stableCnt     <= RELOAD;
            end else begin
                stableCnt <= stableCnt - CW'(1);
            end
        end
    end

    assign SyncLevel = syncB;

endmodule
`endif

// File: rtl/digit_position_counter.sv
// ---------------------------------------------------------------------------
// digit_position_counter
// Button-driven up/down counter over [MIN_VAL, MAX_VAL] with wrap or
// saturate behaviour at the range ends, clear, and clamped load.
// Optional macro DIGITCOUNT_DEBOUNCE_EN inserts press_debounce in front of
// the edge detector (step latency becomes DEB_CYCLES+3 edges).
// Ports:
//   Clk   : clock, rising edge
//   Reset : synchronous, active-low
//   bus   : digit_position_counter_if.slave
//           in : StartCount, Down, Mode, Clear, Load, LoadValue
//           out: CounterValue, Wrap, AtMax, AtMin (all registered)
// ---------------------------------------------------------------------------
module digit_position_counter
    import digit_count_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int MIN_VAL    = DEFAULT_MIN_VAL,
    parameter int MAX_VAL    = DEFAULT_MAX_VAL,
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
    input logic                     Clk,
    input logic                     Reset,
    digit_position_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    if (MIN_VAL < 0 || MIN_VAL > MAX_VAL || MAX_VAL > (2**WIDTH) - 1 ||
        DEB_CYCLES < 2) begin : genParamCheck
        $error("digit_position_counter: illegal WIDTH/MIN_VAL/MAX_VAL/DEB_CYCLES");
    end

    logic             pressQ;
    logic             pressQq;
    logic             armLevel;
    logic             armed;
    logic             step;
    logic             inRange;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] nextCount;
    logic             nextWrap;
    logic             wrapQ;
    logic             atMaxQ;
    logic             atMinQ;

    // ------------------------------------------------------------------
    // Press level source: filtered or raw.
    // ------------------------------------------------------------------
`ifdef DIGITCOUNT_DEBOUNCE_EN
    press_debounce #(
        .DEB_CYCLES    (DEB_CYCLES)
    ) uPressDebounce (
        .Clk           (Clk),
        .Reset         (Reset),
        .RawLevel      (bus.StartCount),
        .SyncLevel     (armLevel),
        .FilteredLevel (pressQ)
    );
`else
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pressQ <= 1'b0;
        end else begin
            pressQ <= bus.StartCount;
        end
    end

    assign armLevel = bus.StartCount;
`endif

    // ------------------------------------------------------------------
    // Edge detector. After reset the detector stays disarmed until the
    // button has been seen low once, so a press held through reset is
    // discarded rather than counted on release of reset.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pressQq <= 1'b0;
            armed   <= 1'b0;
        end else begin
            pressQq <= pressQ;
            if (!armLevel) begin
                armed <= 1'b1;
            end
        end
    end

    assign step = pressQ & ~pressQq & armed;

    // ------------------------------------------------------------------
    // Next count. Clear and Load swallow a coincident step.
    // ------------------------------------------------------------------
    always_comb begin
        nextCount = count;
        nextWrap  = 1'b0;
        inRange   = (count >= MIN_V) && (count <= MAX_V);

        if (bus.Clear) begin
            nextCount = '0;
        end else if (bus.Load) begin
            if (bus.LoadValue < MIN_V) begin
                nextCount = MIN_V;
            end else if (bus.LoadValue > MAX_V) begin
                nextCount = MAX_V;
            end else begin
                nextCount = bus.LoadValue;
            end
        end else if (step) begin
            if (!inRange) begin
                // Out-of-range values (e.g. 0 after clear) re-enter at the
                // end of the range the step is heading toward.
                nextCount = (bus.Down == DIR_DOWN) ? MAX_V : MIN_V;
            end else if (bus.Down == DIR_UP) begin
                if (count == MAX_V) begin
                    if (bus.Mode == MODE_WRAP) begin
                        nextCount = MIN_V;
                        nextWrap  = 1'b1;
                    end
                end else begin
                    nextCount = count + WIDTH'(1);
                end
            end else begin
                if (count == MIN_V) begin
                    if (bus.Mode == MODE_WRAP) begin
                        nextCount = MAX_V;
                        nextWrap  = 1'b1;
                    end
                end else begin
                    nextCount = count - WIDTH'(1);
                end
            end
        end
    end

    // Flags are derived from nextCount so they line up with CounterValue.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count  <= '0;
            wrapQ  <= 1'b0;
            atMaxQ <= 1'b0;
            atMinQ <= (MIN_VAL == 0);
        end else begin
            count  <= nextCount;
            wrapQ  <= nextWrap;
            atMaxQ <= (nextCount == MAX_V);
            atMinQ <= (nextCount == MIN_V);
        end
    end

    assign bus.CounterValue = count;
    assign bus.Wrap         = wrapQ;
    assign bus.AtMax        = atMaxQ;
    assign bus.AtMin        = atMinQ;

endmodule

// File: tb/tb_digit_position_counter.sv
// ---------------------------------------------------------------------------
// tb_digit_position_counter
// Directed scenarios followed by random press/load/clear traffic, every
// observation compared against a plain-arithmetic model of the counter.
// Works with or without DIGITCOUNT_DEBOUNCE_EN.
// ---------------------------------------------------------------------------
module tb_digit_position_counter;
    import digit_count_pkg::*;

    localparam int WIDTH      = 4;
    localparam int MIN_VAL    = 1;
    localparam int MAX_VAL    = 5;
    localparam int DEB_CYCLES = 16;

`ifdef DIGITCOUNT_DEBOUNCE_EN
    localparam int STEP_EDGES = DEB_CYCLES + 3;
    localparam int SETTLE     = DEB_CYCLES + 5;
`else
    localparam int STEP_EDGES = 2;
    localparam int SETTLE     = 1;
`endif

    logic clk;
    logic reset;

    digit_position_counter_if #(.WIDTH(WIDTH)) bus ();

    digit_position_counter #(
        .WIDTH      (WIDTH),
        .MIN_VAL    (MIN_VAL),
        .MAX_VAL    (MAX_VAL),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;
    int mVal      = 0;
    bit mWrap     = 1'b0;

    function automatic int modelStep(input int v, input bit down, input bit sat,
                                     output bit w);
        w = 1'b0;
        if (v < MIN_VAL || v > MAX_VAL) return down ? MAX_VAL : MIN_VAL;
        if (!down) begin
            if (v < MAX_VAL) return v + 1;
            if (sat) return v;
            w = 1'b1;
            return MIN_VAL;
        end
        if (v > MIN_VAL) return v - 1;
        if (sat) return v;
        w = 1'b1;
        return MAX_VAL;
    endfunction

    function automatic int modelLoad(input int v);
        if (v < MIN_VAL) return MIN_VAL;
        if (v > MAX_VAL) return MAX_VAL;
        return v;
    endfunction

    task automatic checkAll(input string tag);
        nCompared++;
        assert (bus.CounterValue === WIDTH'(mVal)) else begin
            nMismatch++;
            $error("FAIL %s value: got %0d expected %0d", tag, bus.CounterValue, mVal);
        end
        nCompared++;
        assert (bus.Wrap === mWrap) else begin
            nMismatch++;
            $error("FAIL %s wrap: got %b expected %b", tag, bus.Wrap, mWrap);
        end
        nCompared++;
        assert (bus.AtMax === (mVal == MAX_VAL)) else begin
            nMismatch++;
            $error("FAIL %s atmax: got %b expected %b", tag, bus.AtMax, (mVal == MAX_VAL));
        end
        nCompared++;
        assert (bus.AtMin === (mVal == MIN_VAL)) else begin
            nMismatch++;
            $error("FAIL %s atmin: got %b expected %b", tag, bus.AtMin, (mVal == MIN_VAL));
        end
    endtask

    task automatic checkValue(input string tag, input int expected);
        nCompared++;
        assert (bus.CounterValue === WIDTH'(expected)) else begin
            nMismatch++;
            $error("FAIL %s: got %0d expected %0d", tag, bus.CounterValue, expected);
        end
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mVal  = 0;
        mWrap = 1'b0;
        checkAll(tag);
        reset = 1'b1;
        repeat (SETTLE + 2) @(negedge clk);
    endtask

    // One press: checks the value is unchanged one edge before the step
    // lands, then the step itself, then quiet after release.
    task automatic doPress(input bit down, input bit sat, input int extraHold,
                           input int relCycles, input string tag);
        int nxt;
        bit w;
        @(negedge clk);
        bus.Down       = down;
        bus.Mode       = sat;
        bus.StartCount = 1'b1;
        nxt = modelStep(mVal, down, sat, w);
        repeat (STEP_EDGES - 1) @(posedge clk);
        @(negedge clk);
        mWrap = 1'b0;
        checkAll({tag, "_pre"});
        @(negedge clk);
        mVal  = nxt;
        mWrap = w;
        checkAll(tag);
        repeat (extraHold) @(negedge clk);
        bus.StartCount = 1'b0;
        repeat (relCycles) @(negedge clk);
        mWrap = 1'b0;
        checkAll({tag, "_rel"});
    endtask

    task automatic doLoad(input int v, input string tag);
        @(negedge clk);
        bus.Load      = 1'b1;
        bus.LoadValue = WIDTH'(v);
        @(negedge clk);
        bus.Load = 1'b0;
        mVal  = modelLoad(v);
        mWrap = 1'b0;
        checkAll(tag);
    endtask

    task automatic doClear(input string tag);
        @(negedge clk);
        bus.Clear = 1'b1;
        @(negedge clk);
        bus.Clear = 1'b0;
        mVal  = 0;
        mWrap = 1'b0;
        checkAll(tag);
    endtask

    // Clear or Load arriving on the very edge a step would be applied.
    task automatic doCollide(input bit useClear, input int lv, input string tag);
        @(negedge clk);
        bus.Down       = 1'b0;
        bus.Mode       = 1'b0;
        bus.StartCount = 1'b1;
        repeat (STEP_EDGES - 1) @(posedge clk);
        @(negedge clk);
        if (useClear) bus.Clear = 1'b1;
        else begin
            bus.Load      = 1'b1;
            bus.LoadValue = WIDTH'(lv);
        end
        @(negedge clk);
        bus.Clear = 1'b0;
        bus.Load  = 1'b0;
        mVal  = useClear ? 0 : modelLoad(lv);
        mWrap = 1'b0;
        checkAll(tag);
        repeat (3) @(negedge clk);
        checkAll({tag, "_nostep"});
        bus.StartCount = 1'b0;
        repeat (SETTLE + 1) @(negedge clk);
    endtask

    int upSeq[6]   = '{1, 2, 3, 4, 5, 1};
    int downSeq[6] = '{5, 4, 3, 2, 1, 5};

    initial begin
        reset          = 1'b0;
        bus.StartCount = 1'b0;
        bus.Down       = 1'b0;
        bus.Mode       = 1'b0;
        bus.Clear      = 1'b0;
        bus.Load       = 1'b0;
        bus.LoadValue  = '0;

        doReset("reset");

        for (int i = 0; i < 6; i++) begin
            doPress(1'b0, 1'b0, 0, SETTLE, $sformatf("up_wrap%0d", i));
            checkValue($sformatf("up_seq%0d", i), upSeq[i]);
        end

        doLoad(5, "sat_load5");
        for (int i = 0; i < 2; i++)
            doPress(1'b0, 1'b1, 1, SETTLE, $sformatf("up_sat%0d", i));

        doClear("clear0");
        for (int i = 0; i < 6; i++) begin
            doPress(1'b1, 1'b0, 0, SETTLE, $sformatf("down_wrap%0d", i));
            checkValue($sformatf("down_seq%0d", i), downSeq[i]);
        end

        doPress(1'b1, 1'b1, 0, SETTLE, "down_sat_step");
        doPress(1'b1, 1'b0, 0, SETTLE, "down_wrap_after");
        doLoad(1, "load1");
        doPress(1'b1, 1'b1, 0, SETTLE, "down_sat_min");

        doLoad(9, "load9");
        checkValue("load9_clamp", MAX_VAL);
        doLoad(0, "load0");
        checkValue("load0_clamp", MIN_VAL);
        doLoad(3, "load3");
        doCollide(1'b1, 0, "clear_collide");
        doLoad(3, "load3b");
        doCollide(1'b0, 2, "load_collide");

        doLoad(2, "hold_load2");
        doPress(1'b0, 1'b0, 20, SETTLE, "hold20");

        // Reset pulsed while the button is held: no step until re-press.
        @(negedge clk);
        bus.Down       = 1'b0;
        bus.Mode       = 1'b0;
        bus.StartCount = 1'b1;
        repeat (STEP_EDGES) @(posedge clk);
        @(negedge clk);
        mVal  = 4;
        mWrap = 1'b0;
        checkAll("midhold_step");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mVal  = 0;
        checkAll("midhold_reset");
        repeat (STEP_EDGES + 10) @(negedge clk);
        checkAll("midhold_still");
        bus.StartCount = 1'b0;
        repeat (SETTLE + 2) @(negedge clk);
        checkAll("midhold_release");
        doPress(1'b0, 1'b0, 0, SETTLE, "midhold_repress");

`ifdef DIGITCOUNT_DEBOUNCE_EN
        @(negedge clk);
        bus.StartCount = 1'b1;
        repeat (5) @(negedge clk);
        bus.StartCount = 1'b0;
        repeat (DEB_CYCLES + 8) @(negedge clk);
        checkAll("glitch5");
        doPress(1'b0, 1'b0, 30 - STEP_EDGES, SETTLE, "press30");
`endif

        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op == 0) begin
                doClear($sformatf("rnd%0d_clear", i));
            end else if (op <= 2) begin
                doLoad($urandom_range(0, 15), $sformatf("rnd%0d_load", i));
            end else begin
                doPress(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 2),
                        SETTLE + $urandom_range(0, 2),
                        $sformatf("rnd%0d_press", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
